// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frame sequencer between the UART receiver, a combinational
// ALU and the UART transmitter. It collects operand A, operand B and the opcode,
// then captures the ALU result and sends it with a start/done handshake.
// Optional inter-byte timeout is enabled by defining UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NB_DATA-1:0] alu_a_nxt;
  logic [NB_DATA-1:0] alu_b_nxt;
  logic [NB_OP-1:0]   alu_op_nxt;
  logic [NB_DATA-1:0] tx_data_nxt;
  logic               tx_start_nxt;
  logic               busy_nxt;
  logic               overrun_nxt;
  logic               timeout_nxt;
  logic               timer_expired;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          in_frame;

  assign in_frame = (state == GET_B) || (state == GET_OP);
  // A received byte always wins over an expiry in the same cycle.
  assign timer_expired = in_frame && !i_rx_done && (timer == T_LAST);

  // Inter-byte idle counter: cleared by every byte and outside the frame body, saturating.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      timer <= '0;
    end else if (i_rx_done || !in_frame || (state_nxt == GET_A)) begin
      timer <= '0;
    end else if (timer != T_LAST) begin
      timer <= timer + TW'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timer_expired      = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt    = state;
    alu_a_nxt    = o_alu_a;
    alu_b_nxt    = o_alu_b;
    alu_op_nxt   = o_alu_op;
    tx_data_nxt  = o_tx_data;
    tx_start_nxt = 1'b0;
    overrun_nxt  = 1'b0;
    timeout_nxt  = 1'b0;
    case (state)
      GET_A: begin
        if (i_rx_done) begin
          alu_a_nxt = i_rx_data;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (i_rx_done) begin
          alu_b_nxt = i_rx_data;
          state_nxt = GET_OP;
        end else if (timer_expired) begin
          timeout_nxt = 1'b1;
          state_nxt   = GET_A;
        end
      end
      GET_OP: begin
        if (i_rx_done) begin
          alu_op_nxt = i_rx_data[NB_OP-1:0];
          state_nxt  = EXEC;
        end else if (timer_expired) begin
          timeout_nxt = 1'b1;
          state_nxt   = GET_A;
        end
      end
      EXEC: begin
        overrun_nxt  = i_rx_done;
        tx_data_nxt  = i_alu_result;
        tx_start_nxt = 1'b1;
        state_nxt    = SEND;
      end
      SEND: begin
        overrun_nxt = i_rx_done;
        state_nxt   = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_nxt = i_rx_done;
        if (i_tx_done) begin
          state_nxt = GET_A;
        end
      end
      default: begin
        state_nxt = GET_A;
      end
    endcase
    busy_nxt = (state_nxt == EXEC) || (state_nxt == SEND) || (state_nxt == WAIT_TX);
  end

  // State and output registers; reset overrides every event.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= GET_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_alu_a    <= alu_a_nxt;
      o_alu_b    <= alu_b_nxt;
      o_alu_op   <= alu_op_nxt;
      o_tx_data  <= tx_data_nxt;
      o_tx_start <= tx_start_nxt;
      o_busy     <= busy_nxt;
      o_overrun  <= overrun_nxt;
      o_timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: table-driven per-cycle vectors plus
// hand-written sequences for timeout and reset-abort behaviour.
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_alu_ctrl #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_rx_done(rx_done),
    .i_rx_data(rx_data),
    .i_alu_result(alu_result),
    .i_tx_done(tx_done),
    .o_alu_a(alu_a),
    .o_alu_b(alu_b),
    .o_alu_op(alu_op),
    .o_tx_start(tx_start),
    .o_tx_data(tx_data),
    .o_busy(busy),
    .o_overrun(overrun),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Bench ALU: 0x20 add, 0x22 sub, otherwise bitwise and.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  typedef struct {
    logic       rx;
    logic [7:0] data;
    logic       txd;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic       st;
    logic [7:0] txdat;
    logic       bsy;
    logic       ovr;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic t);
    @(negedge clk);
    rx_done = r;
    rx_data = d;
    tx_done = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".a"}, 32'(alu_a), 32'h0);
    chk({tag, ".b"}, 32'(alu_b), 32'h0);
    chk({tag, ".op"}, 32'(alu_op), 32'h0);
    chk({tag, ".tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, ".tx_start"}, 32'(tx_start), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".overrun"}, 32'(overrun), 32'h0);
    chk({tag, ".timeout"}, 32'(timeout), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    //            rx    data   txd   a      b      op     st    txdat  bsy   ovr
    vecs[0]  = '{1'b1, 8'h05, 1'b0, 8'h05, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h03, 1'b0, 8'h05, 8'h03, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h20, 1'b0, 8'h05, 8'h03, 6'h20, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h05, 8'h03, 6'h20, 1'b1, 8'h08, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h05, 8'h03, 6'h20, 1'b0, 8'h08, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'hAA, 1'b0, 8'h05, 8'h03, 6'h20, 1'b0, 8'h08, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h05, 8'h03, 6'h20, 1'b0, 8'h08, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h05, 8'h03, 6'h20, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h10, 1'b0, 8'h10, 8'h03, 6'h20, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h01, 1'b0, 8'h10, 8'h01, 6'h20, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h22, 1'b0, 8'h10, 8'h01, 6'h22, 1'b0, 8'h08, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'h55, 1'b0, 8'h10, 8'h01, 6'h22, 1'b1, 8'h0F, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h10, 8'h01, 6'h22, 1'b0, 8'h0F, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 8'h77, 1'b1, 8'h10, 8'h01, 6'h22, 1'b0, 8'h0F, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 8'h33, 1'b0, 8'h33, 8'h01, 6'h22, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 8'h02, 1'b0, 8'h33, 8'h02, 6'h22, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'hE0, 1'b0, 8'h33, 8'h02, 6'h20, 1'b0, 8'h0F, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 8'h33, 8'h02, 6'h20, 1'b1, 8'h35, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 8'h33, 8'h02, 6'h20, 1'b0, 8'h35, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 8'h33, 8'h02, 6'h20, 1'b0, 8'h35, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 8'h33, 8'h02, 6'h20, 1'b0, 8'h35, 1'b0, 1'b0};

    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rx, vecs[i].data, vecs[i].txd);
      chk($sformatf("v%0d.a", i), 32'(alu_a), 32'(vecs[i].a));
      chk($sformatf("v%0d.b", i), 32'(alu_b), 32'(vecs[i].b));
      chk($sformatf("v%0d.op", i), 32'(alu_op), 32'(vecs[i].op));
      chk($sformatf("v%0d.tx_start", i), 32'(tx_start), 32'(vecs[i].st));
      chk($sformatf("v%0d.tx_data", i), 32'(tx_data), 32'(vecs[i].txdat));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("v%0d.overrun", i), 32'(overrun), 32'(vecs[i].ovr));
      chk($sformatf("v%0d.timeout", i), 32'(timeout), 32'h0);
    end

    // Inter-byte timeout: one byte, then 20 idle cycles.
    drive(1'b1, 8'h07, 1'b0);
    chk("to.a_loaded", 32'(alu_a), 32'h07);
    pulses = 0;
    for (int i = 1; i < 20; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      if (timeout) pulses++;
    end
    chk("to.early_pulses", 32'(pulses), 32'h0);
    drive(1'b0, 8'h00, 1'b0);
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    chk("to.pulse", 32'(timeout), 32'h1);
`else
    chk("to.pulse", 32'(timeout), 32'h0);
`endif
    chk("to.a_kept", 32'(alu_a), 32'h07);
    drive(1'b0, 8'h00, 1'b0);
    chk("to.pulse_end", 32'(timeout), 32'h0);
    drive(1'b1, 8'h09, 1'b0);
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    chk("to.next_a", 32'(alu_a), 32'h09);
    chk("to.next_b", 32'(alu_b), 32'h02);
`else
    chk("to.next_a", 32'(alu_a), 32'h07);
    chk("to.next_b", 32'(alu_b), 32'h09);
`endif

    // Reset clears a half-built frame.
    @(negedge clk);
    rst     = 1'b1;
    rx_done = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst2");
    @(negedge clk);
    rst = 1'b0;

    // Reset while in SEND aborts the reply.
    drive(1'b1, 8'h04, 1'b0);
    drive(1'b1, 8'h05, 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("abort.tx_start", 32'(tx_start), 32'h1);
    chk("abort.tx_data", 32'(tx_data), 32'h09);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      if (tx_start || busy) pulses++;
    end
    chk("abort.no_restart", 32'(pulses), 32'h0);
    drive(1'b1, 8'h44, 1'b0);
    chk("abort.next_a", 32'(alu_a), 32'h44);
    chk("abort.next_b", 32'(alu_b), 32'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
